// File: rtl/seg_dyn_scan.sv
// seg_dyn_scan: six-digit multiplexed common-anode seven-segment driver.
// A 20-bit binary input is clamped to 999_999, converted to six BCD digits
// by a sequential double-dabble FSM, and scanned onto sel/seg (both active-low).
// Optional build macro: SEG_BLANK_ZERO_EN enables leading-zero blanking.
module seg_dyn_scan #(
    parameter logic [15:0] CNT_MAX = 16'd49_999
) (
    input  logic        sys_clk,
    input  logic        rst_n,
    input  logic [19:0] data,
    input  logic [5:0]  point,
    input  logic        sign,
    input  logic        seg_en,
    output logic [5:0]  sel,
    output logic [7:0]  seg
);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } conv_state_t;

    localparam logic [19:0] DATA_MAX = 20'd999_999;

    conv_state_t state_q, state_d;
    logic [19:0] data_last_q, data_last_d;
    logic [43:0] sreg_q, sreg_d;
    logic [4:0]  bit_cnt_q, bit_cnt_d;
    logic [23:0] bcd_disp_q, bcd_disp_d;
    logic [15:0] cnt_1ms_q, cnt_1ms_d;
    logic [2:0]  cnt_sel_q, cnt_sel_d;
    logic [5:0]  sel_q, sel_d;
    logic [7:0]  seg_q, seg_d;

    logic [43:0] adj;
    logic [23:0] bcd_shifted;
    logic [3:0]  nib;
    logic [6:0]  seg7;
    logic        non_bcd;
    logic [5:0]  lead_blank;

    // Double-dabble converter: capture changed input, 20 add-3/shift steps, publish.
    always_comb begin
        state_d     = state_q;
        data_last_d = data_last_q;
        sreg_d      = sreg_q;
        bit_cnt_d   = bit_cnt_q;
        bcd_disp_d  = bcd_disp_q;
        adj         = sreg_q;
        case (state_q)
            IDLE: begin
                if (data != data_last_q) begin
                    sreg_d      = {24'h000000, (data > DATA_MAX) ? DATA_MAX : data};
                    data_last_d = data;
                    bit_cnt_d   = '0;
                    state_d     = SHIFT;
                end
            end
            SHIFT: begin
                for (int unsigned i = 0; i < 6; i++) begin
                    if (sreg_q[20 + 4*i +: 4] >= 4'd5)
                        adj[20 + 4*i +: 4] = sreg_q[20 + 4*i +: 4] + 4'd3;
                end
                sreg_d    = adj << 1;
                bit_cnt_d = bit_cnt_q + 5'd1;
                if (bit_cnt_q == 5'd19)
                    state_d = DONE;
            end
            DONE: begin
                bcd_disp_d = sreg_q[43:20];
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Scan timing: per-digit dwell counter and digit index.
    always_comb begin
        cnt_1ms_d = cnt_1ms_q + 16'd1;
        cnt_sel_d = cnt_sel_q;
        if (cnt_1ms_q == CNT_MAX) begin
            cnt_1ms_d = '0;
            cnt_sel_d = (cnt_sel_q == 3'd5) ? 3'd0 : cnt_sel_q + 3'd1;
        end
    end

    // Leading-zero blank mask: a digit blanks only while it and every higher
    // digit are zero with no decimal point lit; digit 0 never blanks.
    always_comb begin
        lead_blank = '0;
`ifdef SEG_BLANK_ZERO_EN
        lead_blank[5] = (bcd_disp_q[23:20] == 4'd0) && !point[5];
        for (int unsigned i = 1; i < 5; i++) begin
            lead_blank[5-i] = lead_blank[6-i] && (bcd_disp_q[4*(5-i) +: 4] == 4'd0)
                              && !point[5-i];
        end
`endif
    end

    // Segment decode for the digit currently selected.
    always_comb begin
        bcd_shifted = bcd_disp_q >> {cnt_sel_q, 2'b00};
        nib         = bcd_shifted[3:0];
        non_bcd     = 1'b0;
        case (nib)
            4'd0:    seg7 = 7'h40;
            4'd1:    seg7 = 7'h79;
            4'd2:    seg7 = 7'h24;
            4'd3:    seg7 = 7'h30;
            4'd4:    seg7 = 7'h19;
            4'd5:    seg7 = 7'h12;
            4'd6:    seg7 = 7'h02;
            4'd7:    seg7 = 7'h78;
            4'd8:    seg7 = 7'h00;
            4'd9:    seg7 = 7'h10;
            default: begin
                seg7    = 7'h7F;
                non_bcd = 1'b1;
            end
        endcase
    end

    // Output select/segment next values; dark when disabled.
    always_comb begin
        sel_d = '1;
        seg_d = '1;
        if (seg_en) begin
            sel_d = ~(6'b000001 << cnt_sel_q);
            if (!non_bcd && !lead_blank[cnt_sel_q])
                seg_d = {~point[cnt_sel_q], seg7};
            if (cnt_sel_q == 3'd5 && sign)
                seg_d = {~point[5], 7'b011_1111};
        end
    end

    // All state registers, asynchronous active-low reset.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            data_last_q <= '0;
            sreg_q      <= '0;
            bit_cnt_q   <= '0;
            bcd_disp_q  <= '0;
            cnt_1ms_q   <= '0;
            cnt_sel_q   <= '0;
            sel_q       <= '1;
            seg_q       <= '1;
        end else begin
            state_q     <= state_d;
            data_last_q <= data_last_d;
            sreg_q      <= sreg_d;
            bit_cnt_q   <= bit_cnt_d;
            bcd_disp_q  <= bcd_disp_d;
            cnt_1ms_q   <= cnt_1ms_d;
            cnt_sel_q   <= cnt_sel_d;
            sel_q       <= sel_d;
            seg_q       <= seg_d;
        end
    end

    assign sel = sel_q;
    assign seg = seg_q;

endmodule

// File: tb/tb_seg_dyn_scan.sv
// tb_seg_dyn_scan: directed bench for seg_dyn_scan with CNT_MAX = 9.
module tb_seg_dyn_scan;

    logic        sys_clk = 1'b0;
    logic        rst_n;
    logic [19:0] data;
    logic [5:0]  point;
    logic        sign;
    logic        seg_en;
    logic [5:0]  sel;
    logic [7:0]  seg;

    int n_chk  = 0;
    int n_pass = 0;

`ifdef SEG_BLANK_ZERO_EN
    localparam logic [7:0] LZ = 8'hFF;
`else
    localparam logic [7:0] LZ = 8'hC0;
`endif

    seg_dyn_scan #(.CNT_MAX(16'd9)) dut (
        .sys_clk (sys_clk),
        .rst_n   (rst_n),
        .data    (data),
        .point   (point),
        .sign    (sign),
        .seg_en  (seg_en),
        .sel     (sel),
        .seg     (seg)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Wait for the first negedge at which digit k becomes newly selected.
    task automatic wait_digit(input int k);
        logic [5:0] tgt;
        int n;
        tgt = ~(6'b000001 << k);
        n = 0;
        while (sel == tgt && n < 200) begin @(negedge sys_clk); n++; end
        while (sel != tgt && n < 200) begin @(negedge sys_clk); n++; end
        chk($sformatf("sel_d%0d", k), {26'd0, sel}, {26'd0, tgt});
    endtask

    task automatic chk_digit(input int k, input logic [7:0] exp);
        wait_digit(k);
        chk($sformatf("seg_d%0d", k), {24'd0, seg}, {24'd0, exp});
    endtask

    initial begin
        rst_n  = 1'b0;
        data   = 20'd0;
        point  = 6'b000000;
        sign   = 1'b0;
        seg_en = 1'b1;
        repeat (3) @(negedge sys_clk);
        chk("rst_sel", {26'd0, sel}, 32'h3F);
        chk("rst_seg", {24'd0, seg}, 32'hFF);
        rst_n = 1'b1;

        // Scan order and dwell after reset: all zeros displayed.
        wait_digit(0);
        for (int k = 0; k < 6; k++) begin
            chk($sformatf("scan_sel%0d", k), {26'd0, sel}, {26'd0, ~(6'b000001 << k)});
            chk($sformatf("scan_seg%0d", k), {24'd0, seg}, (k == 0) ? 32'hC0 : {24'd0, LZ});
            repeat (10) @(negedge sys_clk);
        end

        // 123456: conversion latency is exactly 22 edges.
        data = 20'd123456;
        repeat (21) @(negedge sys_clk);
        chk("bcd_lat21", {8'd0, dut.bcd_disp_q}, 32'h000000);
        @(negedge sys_clk);
        chk("bcd_lat22", {8'd0, dut.bcd_disp_q}, 32'h123456);
        chk_digit(0, 8'h82);
        chk_digit(5, 8'hF9);
        chk_digit(3, 8'hB0);

        // Clamp above 999_999.
        data = 20'd1_000_000;
        repeat (30) @(negedge sys_clk);
        chk("bcd_clamp", {8'd0, dut.bcd_disp_q}, 32'h999999);
        for (int k = 0; k < 6; k++) chk_digit(k, 8'h90);

        // Change during SHIFT is picked up after the first conversion finishes.
        data = 20'd100;
        repeat (5) @(negedge sys_clk);
        data = 20'd200;
        repeat (16) @(negedge sys_clk);
        chk("chg_e21", {8'd0, dut.bcd_disp_q}, 32'h999999);
        @(negedge sys_clk);
        chk("chg_e22", {8'd0, dut.bcd_disp_q}, 32'h000100);
        repeat (21) @(negedge sys_clk);
        chk("chg_e43", {8'd0, dut.bcd_disp_q}, 32'h000100);
        @(negedge sys_clk);
        chk("chg_e44", {8'd0, dut.bcd_disp_q}, 32'h000200);

        // Decimal point, sign, and blanking boundary.
        point = 6'b000100;
        sign  = 1'b1;
        data  = 20'd42;
        repeat (25) @(negedge sys_clk);
        chk_digit(0, 8'hA4);
        chk_digit(1, 8'h99);
        chk_digit(2, 8'h40);
        chk_digit(3, LZ);
        chk_digit(4, LZ);
        chk_digit(5, 8'hBF);

        // seg_en off mid-digit, then back on: scan phase is preserved.
        wait_digit(2);
        repeat (3) @(negedge sys_clk);
        seg_en = 1'b0;
        @(negedge sys_clk);
        chk("off_sel", {26'd0, sel}, 32'h3F);
        chk("off_seg", {24'd0, seg}, 32'hFF);
        repeat (14) @(negedge sys_clk);
        chk("off_sel2", {26'd0, sel}, 32'h3F);
        seg_en = 1'b1;
        @(negedge sys_clk);
        chk("on_sel3", {26'd0, sel}, 32'h37);
        chk("on_seg3", {24'd0, seg}, {24'd0, LZ});
        @(negedge sys_clk);
        chk("on_sel4", {26'd0, sel}, 32'h2F);

        // Reset mid-conversion discards the partial result.
        data = 20'd777;
        repeat (8) @(negedge sys_clk);
        rst_n = 1'b0;
        @(negedge sys_clk);
        chk("rst2_bcd", {8'd0, dut.bcd_disp_q}, 32'h000000);
        chk("rst2_sel", {26'd0, sel}, 32'h3F);
        rst_n = 1'b1;
        repeat (23) @(negedge sys_clk);
        chk("rst2_conv", {8'd0, dut.bcd_disp_q}, 32'h000777);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
